// File: rtl/led_pattern_engine.sv
// rtl/led_pattern_engine.sv - N-LED pattern generator (run-right, run-left, bounce, auto)
//
// Steps the LED bank once per single-cycle tick. The tick comes either from the
// programmable internal divider or from a rising edge of the external 555 timer.
// The timer is only ever sampled, never used as a clock, so the block runs
// entirely in the clk domain.
//
// Parameters:
//   N       number of LEDs (N >= 2)
//   DIV_W   width of the divider counter and div port
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset
//   i_timer  external square wave, asynchronous to clk
//   src_sel  tick source: 0 internal divider, 1 i_timer rising edge
//   div      internal tick period minus one
//   mode     00 RUN_R, 01 RUN_L, 10 BOUNCE, 11 AUTO
//   control  switch pattern used by AUTO (target / blink pattern)
//   led      registered LED drive
//   tick     registered one-cycle step strobe
module led_pattern_engine #(
    parameter int N     = 8,
    parameter int DIV_W = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_timer,
    input  logic             src_sel,
    input  logic [DIV_W-1:0] div,
    input  logic [1:0]       mode,
    input  logic [N-1:0]     control,
    output logic [N-1:0]     led,
    output logic             tick
);

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_t;

    localparam logic [1:0] MODE_RUN_R  = 2'b00;
    localparam logic [1:0] MODE_RUN_L  = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_AUTO   = 2'b11;

    localparam logic [N-1:0] LED_MSB    = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] LED_LSB    = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] LED_MSB_DN = LED_MSB >> 1;
    localparam logic [N-1:0] LED_LSB_UP = LED_LSB << 1;

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             s3_q, s3_d;
    logic             tick_q, tick_d;
    logic [N-1:0]     led_q, led_d;
    dir_t             dir_q, dir_d;
    logic             phase_q, phase_d;

    logic             led_onehot;
    logic             ctl_onehot;
    logic [N-1:0]     rot_r;
    logic [N-1:0]     rot_l;

    // Tick generation. The sync chain runs regardless of src_sel so that a
    // timer already high when switching to external produces no spurious tick.
    always_comb begin
        s1_d   = i_timer;
        s2_d   = s1_q;
        s3_d   = s2_q;
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (src_sel) begin
            cnt_d  = '0;
            tick_d = s2_q & ~s3_q;
        end else if (cnt_q >= div) begin
            // >= rather than == so a div lowered below cnt wraps at once
            cnt_d  = '0;
            tick_d = 1'b1;
        end else begin
            cnt_d  = cnt_q + DIV_W'(1);
        end
    end

    // Pattern step, applied only on cycles where the registered tick is high.
    always_comb begin
        led_onehot = $onehot(led_q);
        ctl_onehot = $onehot(control);
        rot_r      = {led_q[0], led_q[N-1:1]};
        rot_l      = {led_q[N-2:0], led_q[N-1]};
        led_d      = led_q;
        dir_d      = dir_q;
        phase_d    = phase_q;
        if (tick_q) begin
            // Blink phase restarts whenever a tick is spent outside blink.
            phase_d = 1'b0;
            unique case (mode)
                MODE_RUN_R: begin
                    if (!led_onehot) begin
                        led_d = LED_MSB;
                        dir_d = DIR_RIGHT;
                    end else begin
                        led_d = rot_r;
                    end
                end
                MODE_RUN_L: begin
                    if (!led_onehot) begin
                        led_d = LED_LSB;
                        dir_d = DIR_RIGHT;
                    end else begin
                        led_d = rot_l;
                    end
                end
                MODE_BOUNCE: begin
                    if (!led_onehot) begin
                        led_d = LED_MSB;
                        dir_d = DIR_RIGHT;
                    end else if (dir_q == DIR_RIGHT) begin
                        // Turn around on the step leaving the end LED so each end is lit one tick.
                        if (led_q[0]) begin
                            led_d = LED_LSB_UP;
                            dir_d = DIR_LEFT;
                        end else begin
                            led_d = led_q >> 1;
                        end
                    end else begin
                        if (led_q[N-1]) begin
                            led_d = LED_MSB_DN;
                            dir_d = DIR_RIGHT;
                        end else begin
                            led_d = led_q << 1;
                        end
                    end
                end
                MODE_AUTO: begin
                    if (control != '0 && !ctl_onehot) begin
                        led_d   = phase_q ? '0 : control;
                        phase_d = ~phase_q;
                    end else if (!led_onehot) begin
                        led_d = LED_MSB;
                        dir_d = DIR_RIGHT;
                    end else if (control == '0 || led_q != control) begin
                        // chase, or walk toward the one-hot target and park on it
                        led_d = rot_r;
                    end
                end
                default: begin
                    led_d = led_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            tick_q  <= 1'b0;
            led_q   <= LED_MSB;
            dir_q   <= DIR_RIGHT;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            tick_q  <= tick_d;
            led_q   <= led_d;
            dir_q   <= dir_d;
            phase_q <= phase_d;
        end
    end

    assign led  = led_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// tb/tb_led_pattern_engine.sv - self-checking bench for led_pattern_engine
module tb_led_pattern_engine;

    localparam int N     = 8;
    localparam int DIV_W = 26;
    localparam logic [N-1:0] ONE = 1;

    logic             clk     = 1'b0;
    logic             rst     = 1'b1;
    logic             i_timer = 1'b0;
    logic             src_sel = 1'b0;
    logic [DIV_W-1:0] div     = '0;
    logic [1:0]       mode    = 2'b00;
    logic [N-1:0]     control = '0;
    logic [N-1:0]     led;
    logic             tick;

    always #5 clk = ~clk;

    led_pattern_engine #(.N(N), .DIV_W(DIV_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_timer (i_timer),
        .src_sel (src_sel),
        .div     (div),
        .mode    (mode),
        .control (control),
        .led     (led),
        .tick    (tick)
    );

    int n_cmp = 0;
    int n_err = 0;

    // reference state: lit pattern, bounce direction, blink phase, pending tick
    logic [N-1:0] m_led;
    bit           m_left;
    bit           m_phase;
    bit           m_tick;
    bit           hist[$];
    int           t_left;
    int           hi_len;
    int           lo_len;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [N-1:0] pick_control();
        int sel;
        sel = $urandom_range(0, 2);
        if (sel == 0) return '0;
        if (sel == 1) return ONE << $urandom_range(0, N-1);
        return N'($urandom);
    endfunction

    // One step by the rules: positions handled as indices, bounce as a
    // walk around a ring of 2N-2 positions.
    task automatic model_step();
        int  b;
        int  k;
        bit  oh;
        oh = $onehot(m_led);
        b  = 0;
        for (int i = 0; i < N; i++) if (m_led[i]) b = i;
        if (mode == 2'd3 && control != '0 && !$onehot(control)) begin
            m_led   = m_phase ? '0 : control;
            m_phase = !m_phase;
            return;
        end
        m_phase = 0;
        if (!oh) begin
            m_led  = (mode == 2'd1) ? ONE : (ONE << (N-1));
            m_left = 0;
            return;
        end
        case (mode)
            2'd0: m_led = ONE << ((b + N - 1) % N);
            2'd1: m_led = ONE << ((b + 1) % N);
            2'd2: begin
                k      = m_left ? (N - 1 + b) : (N - 1 - b);
                k      = (k + 1) % (2*N - 2);
                m_led  = ONE << ((k <= N-1) ? (N - 1 - k) : (k - (N - 1)));
                m_left = (k >= N);
            end
            default: if (control == '0 || m_led != control) m_led = ONE << ((b + N - 1) % N);
        endcase
    endtask

    // Advance the reference across one clock edge using the inputs seen at it.
    task automatic model_edge();
        int e;
        bit prev;
        hist.push_back(i_timer);
        e = hist.size();
        if (m_tick) model_step();
        if (src_sel) begin
            prev   = (e >= 4) ? hist[e-4] : 1'b0;
            m_tick = (e >= 3) && hist[e-3] && !prev;
        end else begin
            m_tick = (e % (int'(div) + 1)) == 0;
        end
    endtask

    task automatic run_cycles(input int n, input bit rnd);
        repeat (n) begin
            @(negedge clk);
            model_edge();
            check("tick", 32'(tick), 32'(m_tick));
            check("led", 32'(led), 32'(m_led));
            if (src_sel) begin
                check("cnt_held", 32'(dut.cnt_q), 32'd0);
                t_left--;
                if (t_left == 0) begin
                    i_timer = !i_timer;
                    t_left  = i_timer ? hi_len : lo_len;
                end
            end
            if (rnd && $urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
            if (rnd && $urandom_range(0, 7) == 0) control = pick_control();
        end
    endtask

    // Asynchronous reset away from any clock edge, checked before the next edge.
    task automatic restart(input bit s, input int d, input int m, input logic [N-1:0] c,
                           input int hi, input int lo);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_led", 32'(led), 32'(1 << (N-1)));
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_cnt", 32'(dut.cnt_q), 32'd0);
        src_sel = s;
        div     = DIV_W'(d);
        mode    = 2'(m);
        control = c;
        i_timer = 1'b0;
        hi_len  = hi;
        lo_len  = lo;
        t_left  = lo;
        @(negedge clk);
        rst     = 1'b0;
        m_led   = ONE << (N-1);
        m_left  = 0;
        m_phase = 0;
        m_tick  = 0;
        hist.delete();
    endtask

    initial begin
        // run-right wrap, then reset mid-count while 0x04 is lit
        restart(0, 3, 0, '0, 1, 1);
        run_cycles(40, 0);
        for (int i = 0; i < 40 && !(m_led == 8'h04 && !m_tick); i++) run_cycles(1, 0);
        check("reached_04", 32'(led), 32'h04);

        // bounce at full rate
        restart(0, 0, 2, '0, 1, 1);
        run_cycles(30, 0);

        // auto target then chase resumes
        restart(0, 1, 3, 8'h10, 1, 1);
        run_cycles(20, 0);
        check("target_hold", 32'(led), 32'h10);
        control = '0;
        run_cycles(10, 0);

        // auto blink then switch to run-left
        restart(0, 1, 3, 8'hA5, 1, 1);
        run_cycles(9, 0);
        mode = 2'd1;
        run_cycles(8, 0);

        // external source: 20-cycle square wave, then 8-cycle high pulses
        restart(1, 0, 0, '0, 10, 10);
        run_cycles(100, 0);
        restart(1, 0, 0, '0, 8, 12);
        run_cycles(60, 0);

        // randomized segments
        for (int s = 0; s < 10; s++) begin
            restart(1'($urandom_range(0, 1)), $urandom_range(0, 5), $urandom_range(0, 3),
                    pick_control(), $urandom_range(1, 6), $urandom_range(1, 6));
            run_cycles(80, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
